// File: rtl/pc_fetch_unit.sv
// Program counter and instruction fetch for a variable-latency instruction memory.
// Each fetched word is presented to the Controller for one EXEC cycle; the PC advances at the end of it.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  PC_s,
  input  logic [31:0] R_Data_A,
  input  logic        halt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        inst_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc, r_inst, r_retired;
  logic [31:0] w_pc_plus4, w_branch_addr, w_jump_addr, w_jr_addr, w_next_pc;
  logic        w_fetch_done, w_exec;

  assign w_fetch_done = (r_state == REQ) && imem_ready;
  assign w_exec       = (r_state == EXEC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // halt only gates the start of a fetch; an outstanding request always completes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = halt ? IDLE : REQ;
      REQ:     w_state_nxt = imem_ready ? EXEC : REQ;
      EXEC:    w_state_nxt = halt ? IDLE : REQ;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_pc_plus4    = r_pc + 32'd4;
  assign w_branch_addr = w_pc_plus4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
  assign w_jump_addr   = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
  assign w_jr_addr     = {R_Data_A[31:2], 2'b00};

  always_comb begin
    w_next_pc = w_pc_plus4;
    case (PC_s)
      2'b00: w_next_pc = w_pc_plus4;
      2'b01: w_next_pc = w_jr_addr;
      2'b10: w_next_pc = w_branch_addr;
      2'b11: w_next_pc = w_jump_addr;
      default: w_next_pc = w_pc_plus4;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_inst    <= 32'h0;
      r_retired <= 32'h0;
    end else begin
      if (w_fetch_done) r_inst <= imem_rdata;
      if (w_exec) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
    end
  end

  assign imem_req   = (r_state == REQ);
  assign imem_addr  = r_pc;
  assign inst_valid = w_exec;
  assign inst       = r_inst;
  assign op         = r_inst[31:26];
  assign func       = r_inst[5:0];
  assign PC         = r_pc;
  assign PC_plus4   = w_pc_plus4;
  assign retired    = r_retired;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch timing, next-PC selection, wait states, halt and reset.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  PC_s;
  logic [31:0] R_Data_A;
  logic        halt;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .PC_s(PC_s), .R_Data_A(R_Data_A), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .inst(inst), .op(op), .func(func),
    .inst_valid(inst_valid), .PC(PC), .PC_plus4(PC_plus4), .retired(retired)
  );

  // instruction memory contents
  always_comb begin
    imem_rdata = 32'h0;
    case (imem_addr)
      32'h00: imem_rdata = 32'h2001_0005; // addi
      32'h04: imem_rdata = 32'h0000_0000; // nop
      32'h08: imem_rdata = 32'h1022_0003; // beq +3
      32'h0C: imem_rdata = 32'h0800_0004; // j 0x10
      32'h10: imem_rdata = 32'h0C00_0020; // jal 0x80
      32'h18: imem_rdata = 32'h0800_0002; // j 0x08
      32'h40: imem_rdata = 32'h0000_0020; // add
      32'h44: imem_rdata = 32'hDEAD_BEEF;
      32'h80: imem_rdata = 32'h00E0_0008; // jr
      default: imem_rdata = 32'h0;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; halt = 1'b1; imem_ready = 1'b0; PC_s = 2'b00; R_Data_A = 32'h0;
    tick(); tick();
    checks++; if (imem_req !== 1'b0)   begin errors++; $display("FAIL reset_req got %b want 0", imem_req); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", inst_valid); end
    checks++; if (PC !== 32'h0)        begin errors++; $display("FAIL reset_pc got %h want 0", PC); end
    checks++; if (inst !== 32'h0)      begin errors++; $display("FAIL reset_inst got %h want 0", inst); end
    checks++; if (retired !== 32'h0)   begin errors++; $display("FAIL reset_retired got %h want 0", retired); end
  endtask

  task automatic test_fetch_basic();
    halt = 1'b0; imem_ready = 1'b1; PC_s = 2'b00;
    rst_n = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got %b want 0", imem_req); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0)
      begin errors++; $display("FAIL req1 got req=%b addr=%h want 1/0", imem_req, imem_addr); end
    checks++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL req1_valid got %b want 0", inst_valid); end
    tick();
    checks++; if (inst_valid !== 1'b1 || op !== 6'b001000 || func !== 6'h05 || inst !== 32'h2001_0005)
      begin errors++; $display("FAIL exec1 got v=%b op=%b func=%h inst=%h want 1/001000/05/20010005", inst_valid, op, func, inst); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL exec1_req got %b want 0", imem_req); end
    tick();
    checks++; if (PC !== 32'h4 || retired !== 32'd1 || imem_req !== 1'b1)
      begin errors++; $display("FAIL after1 got pc=%h ret=%0d req=%b want 4/1/1", PC, retired, imem_req); end
  endtask

  task automatic test_branch();
    PC_s = 2'b00;
    tick(); tick(); // nop at 0x4
    checks++; if (PC !== 32'h8) begin errors++; $display("FAIL nop_pc got %h want 8", PC); end
    PC_s = 2'b10;
    tick();
    checks++; if (inst !== 32'h1022_0003 || inst_valid !== 1'b1)
      begin errors++; $display("FAIL beq_inst got %h v=%b want 10220003/1", inst, inst_valid); end
    tick();
    checks++; if (PC !== 32'h18) begin errors++; $display("FAIL beq_taken_pc got %h want 18", PC); end
    PC_s = 2'b11;
    tick(); tick(); // j 0x08
    checks++; if (PC !== 32'h8) begin errors++; $display("FAIL j_pc got %h want 8", PC); end
    PC_s = 2'b00;
    tick(); tick();
    checks++; if (PC !== 32'hC) begin errors++; $display("FAIL beq_nottaken_pc got %h want c", PC); end
    PC_s = 2'b11;
    tick(); tick(); // j 0x10
    checks++; if (PC !== 32'h10) begin errors++; $display("FAIL j10_pc got %h want 10", PC); end
  endtask

  task automatic test_jal();
    PC_s = 2'b11;
    tick();
    checks++; if (inst_valid !== 1'b1 || op !== 6'b000011 || PC_plus4 !== 32'h14)
      begin errors++; $display("FAIL jal_exec got v=%b op=%b pc4=%h want 1/000011/14", inst_valid, op, PC_plus4); end
    tick();
    checks++; if (PC !== 32'h80) begin errors++; $display("FAIL jal_pc got %h want 80", PC); end
  endtask

  task automatic test_jr();
    PC_s = 2'b01; R_Data_A = 32'h0000_0043;
    tick();
    checks++; if (func !== 6'h08 || inst !== 32'h00E0_0008)
      begin errors++; $display("FAIL jr_exec got func=%h inst=%h want 08/00e00008", func, inst); end
    tick();
    imem_ready = 1'b0;
    checks++; if (PC !== 32'h40) begin errors++; $display("FAIL jr_pc got %h want 40", PC); end
    checks++; if (retired !== 32'd8) begin errors++; $display("FAIL jr_retired got %0d want 8", retired); end
  endtask

  task automatic test_wait_halt();
    PC_s = 2'b00;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40)
      begin errors++; $display("FAIL wait1 got req=%b addr=%h want 1/40", imem_req, imem_addr); end
    tick();
    halt = 1'b1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL wait2 got req=%b addr=%h v=%b want 1/40/0", imem_req, imem_addr, inst_valid); end
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40 || inst_valid !== 1'b0)
      begin errors++; $display("FAIL wait3 got req=%b addr=%h v=%b want 1/40/0", imem_req, imem_addr, inst_valid); end
    imem_ready = 1'b1;
    tick();
    checks++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0020)
      begin errors++; $display("FAIL wait_exec got v=%b inst=%h want 1/00000020", inst_valid, inst); end
    tick();
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || PC !== 32'h44 || retired !== 32'd9)
      begin errors++; $display("FAIL halt_idle got req=%b v=%b pc=%h ret=%0d want 0/0/44/9", imem_req, inst_valid, PC, retired); end
    tick(); // ready high while idle must not load 0xDEADBEEF
    checks++; if (imem_req !== 1'b0 || inst !== 32'h0000_0020 || PC !== 32'h44)
      begin errors++; $display("FAIL idle_hold got req=%b inst=%h pc=%h want 0/00000020/44", imem_req, inst, PC); end
    halt = 1'b0;
    tick();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h44)
      begin errors++; $display("FAIL resume got req=%b addr=%h want 1/44", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    imem_ready = 1'b0;
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || inst_valid !== 1'b0 || retired !== 32'h0 || PC !== 32'h0)
      begin errors++; $display("FAIL async_rst got req=%b v=%b ret=%0d pc=%h want 0/0/0/0", imem_req, inst_valid, retired, PC); end
    imem_ready = 1'b1; halt = 1'b1;
    tick();
    checks++; if (inst !== 32'h0) begin errors++; $display("FAIL rst_stray got inst=%h want 0", inst); end
    rst_n = 1'b1;
    tick(); tick();
    checks++; if (inst !== 32'h0 || imem_req !== 1'b0 || retired !== 32'h0)
      begin errors++; $display("FAIL idle_stray got inst=%h req=%b ret=%0d want 0/0/0", inst, imem_req, retired); end
  endtask

  initial begin
    test_reset();
    test_fetch_basic();
    test_branch();
    test_jal();
    test_jr();
    test_wait_halt();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
- Holds the program counter and fetches instructions from an instruction memory that has variable latency.
- Latches each fetched instruction in an instruction register and presents its fields to the Controller for exactly one execute cycle.
- At the end of that execute cycle, updates the PC from the Controller's PC_s selection.
- Sits directly upstream of the Controller (feeds op/func) and also consumes the Controller's PC_s output.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising-edge.
rst_n  in  1  reset, asynchronous, active-low.
PC_s  in  2  next-PC select from Controller: 00 = PC+4, 01 = R_Data_A (jr), 10 = branch_addr, 11 = jump_addr.
R_Data_A  in  32  register-file read port A; the jr target.
halt  in  1  when high, no new fetch is started.
imem_req  out  1  instruction-fetch request.
imem_addr  out  32  fetch byte address; equals PC.
imem_ready  in  1  memory response strobe; imem_rdata is valid in the same cycle.
imem_rdata  in  32  fetched instruction word.
inst  out  32  instruction register.
op  out  6  inst[31:26].
func  out  6  inst[5:0].
inst_valid  out  1  high only in EXEC; downstream gates Write_Reg and Mem_Write with it.
PC  out  32  current PC.
PC_plus4  out  32  PC+4; used for jal writeback.
retired  out  32  count of completed instructions.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, PC = RESET_PC, inst = 0, retired = 0.
  - imem_req = 0, inst_valid = 0.
  - Reset mid-request abandons the transaction. An imem_ready arriving after reset, with no request outstanding, is ignored.
- State IDLE:
  - imem_req = 0.
  - Next state is REQ if halt = 0, otherwise stay in IDLE.
- State REQ:
  - imem_req = 1, imem_addr = PC; both held stable until imem_ready.
  - On imem_ready: inst <= imem_rdata, go to EXEC. Minimum fetch latency is 1 cycle, when ready arrives in the first REQ cycle.
  - halt rising during REQ does not cancel the request.
- State EXEC (exactly 1 cycle):
  - inst_valid = 1. The Controller decodes combinationally and PC_s is sampled at this edge.
  - PC <= next_pc and retired <= retired + 1.
  - Next state is REQ if halt = 0, otherwise IDLE.
- imem_ready outside REQ is ignored.
- Outside EXEC: inst holds its last value, inst_valid = 0, PC is stable.
- Next-PC arithmetic (all modulo 2^32, overflow wraps silently):
  - PC_plus4 = PC + 4.
  - branch_addr = PC_plus4 + (sign_extend(inst[15:0]) << 2).
  - jump_addr = {PC_plus4[31:28], inst[25:0], 2'b00}.
  - jr target = {R_Data_A[31:2], 2'b00}; low bits are forced to zero, and no fault is raised.
- PC_s is acted on only in EXEC; its value in other states is don't-care.
- Throughput: with zero-wait memory, one instruction completes every 2 cycles (REQ, EXEC).
- retired wraps from 0xFFFF_FFFF to 0.

Test Plan:
1. Reset with RESET_PC = 0, then release, imem_ready tied high, rdata = 0x20010005 (addi), PC_s = 00 -> cycle 1 IDLE; cycle 2 imem_req = 1, addr = 0x0; cycle 3 inst_valid = 1, op = 001000; then PC = 0x4, retired = 1.
2. PC = 0x8, inst = 0x10220003 (beq, offset 3), PC_s = 10 -> PC becomes 0x18. Repeat with PC_s = 00 -> PC becomes 0xC.
3. PC = 0x10, inst = 0x0C000020 (jal), PC_s = 11 -> in EXEC, PC_plus4 = 0x14; afterwards PC = 0x80.
4. inst = 0x00E00008 (jr), R_Data_A = 0x0000_0043, PC_s = 01 -> PC = 0x40.
5. Ready delayed 3 cycles -> imem_req and imem_addr stay stable for 3 cycles, then EXEC. Assert halt in the 2nd REQ cycle -> the fetch still completes, EXEC runs, then the unit stays in IDLE. Deassert halt -> REQ with the new PC.
6. Drop rst_n during REQ with ready pending -> imem_req, inst_valid and retired clear immediately and PC = RESET_PC. A stray imem_ready during reset or in IDLE leaves inst unchanged.
